// File: rtl/ap_div_pkg.sv
// Shared widths, FSM encoding and quotient type for the sequential unsigned divider.
package ap_div_pkg;

    localparam int DW_D  = 24;
    localparam int DW_Q  = 12;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    typedef logic [DW_Q-1:0] q_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract the divisor if it fits.
module div_step
    import ap_div_pkg::*;
(
    input  logic [DW_Q-1:0] i_r,
    input  logic            i_dvd_bit,
    input  logic [DW_Q-1:0] i_dsr,
    output logic [DW_Q-1:0] o_r_next,
    output logic            o_qbit
);

    logic [DW_Q:0] w_t;

    assign w_t    = {i_r, i_dvd_bit};
    assign o_qbit = (w_t >= {1'b0, i_dsr});
    // Partial remainder stays below the divisor, so the 12b wrap-around difference is exact.
    assign o_r_next = o_qbit ? (w_t[DW_Q-1:0] - i_dsr) : w_t[DW_Q-1:0];

endmodule

// File: rtl/seq_unsi_div_24b_r12.sv
// Multi-cycle 24b/12b unsigned restoring divider with valid/ready handshakes, one quotient bit per cycle.
// Optional feature: define APPROX_DIV_EN to stop after DW_Q-AP_SKIP steps (low quotient bits and remainder forced to 0).
module seq_unsi_div_24b_r12
    import ap_div_pkg::*;
#(
    parameter int AP_SKIP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_D-1:0] dividend,
    input  logic [DW_Q-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_Q-1:0] quo,
    output logic [DW_Q-1:0] rem,
    output logic            div0,
    output logic            ovf,
    output logic            busy
);

`ifdef APPROX_DIV_EN
    localparam int SKIP_EFF = AP_SKIP;
`else
    localparam int SKIP_EFF = AP_SKIP * 0;
`endif
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SKIP_EFF);
    localparam logic [CNT_W-1:0] FIRST_BIT = CNT_W'(DW_Q - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    q_t               r_dvd;
    q_t               r_dsr;
    q_t               r_q;
    q_t               r_r;
    q_t               r_quo;
    q_t               r_rem;
    logic             r_div0;
    logic             r_ovf;

    q_t               w_dvd_hi;
    q_t               w_r_next;
    q_t               w_q_next;
    logic             w_qbit;
    logic             w_dvd_bit;

    assign w_dvd_hi  = dividend[DW_D-1:DW_Q];
    assign w_dvd_bit = r_dvd[r_cnt];
    assign w_q_next  = r_q | (q_t'(w_qbit) << r_cnt);

    div_step u_step (
        .i_r       (r_r),
        .i_dvd_bit (w_dvd_bit),
        .i_dsr     (r_dsr),
        .o_r_next  (w_r_next),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div0  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dsr  <= divisor;
                        r_dvd  <= dividend[DW_Q-1:0];
                        r_r    <= w_dvd_hi;
                        r_cnt  <= FIRST_BIT;
                        r_q    <= '0;
                        r_div0 <= 1'b0;
                        r_ovf  <= 1'b0;
                        // Zero divisor wins over overflow so the two flags are mutually exclusive.
                        if (divisor == '0) begin
                            r_div0  <= 1'b1;
                            r_quo   <= '1;
                            r_rem   <= dividend[DW_Q-1:0];
                            r_state <= DONE;
                        end else if (w_dvd_hi >= divisor) begin
                            r_ovf   <= 1'b1;
                            r_quo   <= '1;
                            r_rem   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_r <= w_r_next;
                    r_q <= w_q_next;
                    if (r_cnt == LAST_BIT) begin
                        r_quo   <= w_q_next;
`ifdef APPROX_DIV_EN
                        r_rem   <= '0;
`else
                        r_rem   <= w_r_next;
`endif
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign quo       = r_quo;
    assign rem       = r_rem;
    assign div0      = r_div0;
    assign ovf       = r_ovf;

endmodule
